// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the
// CPU MEM stage and a debug/loader port. Each access takes three cycles
// (arbitrate, RAM access, response). Fixed CPU priority by default;
// defining DMEM_ARB_RR_EN switches simultaneous requests to round-robin.
`timescale 1ns/1ps

module dmem_arbiter (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        cpu_ce,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [3:0]  dbg_we,
    input  logic [31:0] dbg_din,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        ram_ce,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    state_t      state;
    state_t      state_next;
    owner_t      owner;
    owner_t      owner_next;
    logic        acc_read;
    logic        grant_dbg;
    logic        resp_cpu_read;
    logic        resp_dbg_read;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dbg_rdata_q;

`ifdef DMEM_ARB_RR_EN
    owner_t last_grant;

    // Arbitration: on a tie the requester that did not win last time is served.
    always_comb begin
        grant_dbg = dbg_req && (!cpu_ce || (last_grant == OWN_CPU));
    end

    // Remember who won the most recent grant made from IDLE.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            last_grant <= OWN_DBG;
        end else if ((state == IDLE) && (cpu_ce || dbg_req)) begin
            last_grant <= grant_dbg ? OWN_DBG : OWN_CPU;
        end
    end
`else
    // Arbitration: the CPU always wins a tie so the pipeline is never starved.
    always_comb begin
        grant_dbg = dbg_req && !cpu_ce;
    end
`endif

    // State and owner registers; reset abandons any access in flight.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state <= IDLE;
            owner <= OWN_CPU;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Next-state logic: grant from IDLE, then one access cycle and one response cycle.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (cpu_ce || dbg_req) begin
                    if (grant_dbg) begin
                        state_next = DBG_ACC;
                        owner_next = OWN_DBG;
                    end else begin
                        state_next = CPU_ACC;
                        owner_next = OWN_CPU;
                    end
                end
            end
            CPU_ACC: state_next = RESP;
            DBG_ACC: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM port: driven from the owner's inputs only during the access cycle, zero otherwise.
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = 32'h0000_0000;
        ram_din  = 32'h0000_0000;
        case (state)
            CPU_ACC: begin
                ram_ce   = 1'b1;
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
            end
            DBG_ACC: begin
                ram_ce   = 1'b1;
                ram_we   = dbg_we;
                ram_addr = dbg_addr;
                ram_din  = dbg_din;
            end
            default: begin
                ram_ce   = 1'b0;
            end
        endcase
    end

    // Remember whether the access just issued was a read, so RESP knows to capture data.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            acc_read <= 1'b0;
        end else if (ram_ce) begin
            acc_read <= (ram_we == 4'b0000);
        end
    end

    // Response-cycle qualifiers shared by the data capture and the output bypass.
    always_comb begin
        resp_cpu_read = (state == RESP) && (owner == OWN_CPU) && acc_read;
        resp_dbg_read = (state == RESP) && (owner == OWN_DBG) && acc_read;
    end

    // Read data holding registers, updated only by a completed read of their owner.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            cpu_rdata_q <= 32'h0000_0000;
            dbg_rdata_q <= 32'h0000_0000;
        end else begin
            if (resp_cpu_read) begin
                cpu_rdata_q <= ram_dout;
            end
            if (resp_dbg_read) begin
                dbg_rdata_q <= ram_dout;
            end
        end
    end

    // Requester-facing outputs; read data is forwarded in the response cycle so it
    // is already valid when the stall drops, and held from the register afterwards.
    always_comb begin
        cpu_stall = cpu_ce && !((state == RESP) && (owner == OWN_CPU));
        dbg_ack   = (state == RESP) && (owner == OWN_DBG);
        cpu_rdata = resp_cpu_read ? ram_dout : cpu_rdata_q;
        dbg_rdata = resp_dbg_read ? ram_dout : dbg_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized CPU/debug traffic.
// A transaction-level reference model (grant cycle numbers plus a shadow memory)
// predicts every DUT output each cycle; a behavioural RAM answers the DUT.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        clk;
    logic        cpu_rst;
    logic        cpu_ce;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic [3:0]  dbg_we;
    logic [31:0] dbg_din;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        ram_ce;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (cpu_rst),
        .cpu_ce      (cpu_ce),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_din     (cpu_din),
        .cpu_stall   (cpu_stall),
        .cpu_rdata   (cpu_rdata),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_we      (dbg_we),
        .dbg_din     (dbg_din),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .ram_ce      (ram_ce),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural synchronous RAM: 64 words, data returned one cycle after ram_ce.
    logic [31:0] ram_mem [0:63];
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout <= ram_mem[ram_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr[7:2]][8*b +: 8] = ram_din[8*b +: 8];
            end
        end
    end

    // Reference model: an access granted in cycle g uses the RAM in g+1 and completes in g+2.
    logic [31:0] model_mem [0:63];
    int          cyc;
    bit          m_busy;
    bit          m_own;
    int          m_acc;
    bit          m_read;
    logic [5:0]  m_idx;
    logic [31:0] m_cpu_rd;
    logic [31:0] m_dbg_rd;
    bit          m_last;
    bit          cpu_fin, dbg_fin, rst_seen;
    bit          cpu_active, dbg_active;

    // Report one comparison.
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Advance the reference model across one rising edge.
    function automatic void modelEdge();
        logic [3:0]  w;
        logic [31:0] a, d;
        w = m_own ? dbg_we   : cpu_we;
        a = m_own ? dbg_addr : cpu_addr;
        d = m_own ? dbg_din  : cpu_din;
        if (m_busy && cyc == m_acc) begin
            m_read = (w == 4'b0000);
            m_idx  = a[7:2];
            for (int b = 0; b < 4; b++) begin
                if (w[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
        end else if (m_busy && cyc == m_acc + 1) begin
            if (m_own) begin
                if (m_read) m_dbg_rd = model_mem[m_idx];
                dbg_fin = 1'b1;
            end else begin
                if (m_read) m_cpu_rd = model_mem[m_idx];
                cpu_fin = 1'b1;
            end
            m_busy = 1'b0;
        end else if (!m_busy && (cpu_ce || dbg_req)) begin
`ifdef DMEM_ARB_RR_EN
            m_own = (cpu_ce && dbg_req) ? !m_last : !cpu_ce;
`else
            m_own = !cpu_ce;
`endif
            m_last = m_own;
            m_busy = 1'b1;
            m_acc  = cyc + 1;
        end
        if (cpu_rst) begin
            m_busy   = 1'b0;
            m_cpu_rd = 32'h0;
            m_dbg_rd = 32'h0;
            m_last   = 1'b1;
            rst_seen = 1'b1;
        end
        cyc++;
    endfunction

    task automatic applyStimulus(input logic rst,
                                 input logic ce, input logic [31:0] ca, input logic [3:0] cw, input logic [31:0] cd,
                                 input logic dr, input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd);
        cpu_rst  = rst;
        cpu_ce   = ce;
        cpu_addr = ca;
        cpu_we   = cw;
        cpu_din  = cd;
        dbg_req  = dr;
        dbg_addr = da;
        dbg_we   = dw;
        dbg_din  = dd;
    endtask

    // Compare every DUT output against the model's prediction for this cycle.
    task automatic checkOutput();
        logic        e_ce, e_ack, e_stall;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_din, e_crd, e_drd;
        e_ce = 1'b0; e_ack = 1'b0; e_stall = cpu_ce;
        e_we = 4'b0000; e_addr = 32'h0; e_din = 32'h0;
        e_crd = m_cpu_rd; e_drd = m_dbg_rd;
        if (m_busy && cyc == m_acc) begin
            e_ce   = 1'b1;
            e_we   = m_own ? dbg_we   : cpu_we;
            e_addr = m_own ? dbg_addr : cpu_addr;
            e_din  = m_own ? dbg_din  : cpu_din;
        end else if (m_busy && cyc == m_acc + 1) begin
            if (m_own) begin
                e_ack = 1'b1;
                if (m_read) e_drd = model_mem[m_idx];
            end else begin
                e_stall = 1'b0;
                if (m_read) e_crd = model_mem[m_idx];
            end
        end
        chk("model ram_ce",    32'(ram_ce),    32'(e_ce));
        chk("model ram_we",    32'(ram_we),    32'(e_we));
        chk("model ram_addr",  ram_addr,       e_addr);
        chk("model ram_din",   ram_din,        e_din);
        chk("model dbg_ack",   32'(dbg_ack),   32'(e_ack));
        chk("model cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("model cpu_rdata", cpu_rdata,      e_crd);
        chk("model dbg_rdata", dbg_rdata,      e_drd);
    endtask

    task automatic settle();
        #1;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    // Randomized requesters that obey the hold-until-completion protocol.
    task automatic randomStimulus();
        logic        ce, dr;
        logic [31:0] ca, cd, da, dd;
        logic [3:0]  cw, dw;
        ce = cpu_ce; ca = cpu_addr; cw = cpu_we; cd = cpu_din;
        dr = dbg_req; da = dbg_addr; dw = dbg_we; dd = dbg_din;
        if (rst_seen || cpu_fin) cpu_active = 1'b0;
        if (rst_seen || dbg_fin) dbg_active = 1'b0;
        rst_seen = 1'b0; cpu_fin = 1'b0; dbg_fin = 1'b0;
        if (!cpu_active) begin
            ce = ($urandom_range(0, 2) == 0);
            cpu_active = ce;
            ca = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            cw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cd = $urandom;
        end
        if (!dbg_active) begin
            dr = ($urandom_range(0, 2) == 0);
            dbg_active = dr;
            da = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            dw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            dd = $urandom;
        end else if (m_busy && m_own && cyc == m_acc && $urandom_range(0, 1) == 1) begin
            dr = 1'b0;
        end
        applyStimulus(($urandom_range(0, 79) == 0), ce, ca, cw, cd, dr, da, dw, dd);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i]   = {8'hA5, 8'(i), 16'h5A5A};
            model_mem[i] = {8'hA5, 8'(i), 16'h5A5A};
        end
        ram_mem[4]   = 32'h1234_5678;
        model_mem[4] = 32'h1234_5678;
        cyc = 0; m_busy = 0; m_own = 0; m_acc = 0; m_read = 0; m_idx = 0;
        m_cpu_rd = 0; m_dbg_rd = 0; m_last = 1;
        cpu_fin = 0; dbg_fin = 0; rst_seen = 0; cpu_active = 0; dbg_active = 0;

        // Reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        settle(); advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset cpu_stall", 32'(cpu_stall), 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset dbg_rdata", dbg_rdata, 32'h0);
        chk("reset dbg_ack", 32'(dbg_ack), 32'd0);
        chk("reset ram_ce", 32'(ram_ce), 32'd0);
        advance();

        // CPU read of a preloaded word
        applyStimulus(0, 1, 32'h8000_0010, 4'b0000, 0, 0, 0, 0, 0);
        settle();
        chk("cpu read c0 stall", 32'(cpu_stall), 32'd1);
        chk("cpu read c0 ram_ce", 32'(ram_ce), 32'd0);
        advance();
        settle();
        chk("cpu read c1 ram_ce", 32'(ram_ce), 32'd1);
        chk("cpu read c1 ram_addr", ram_addr, 32'h8000_0010);
        chk("cpu read c1 stall", 32'(cpu_stall), 32'd1);
        advance();
        settle();
        chk("cpu read c2 stall", 32'(cpu_stall), 32'd0);
        chk("cpu read c2 rdata", cpu_rdata, 32'h1234_5678);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("cpu rdata held", cpu_rdata, 32'h1234_5678);
        advance();

        // Debug write, then CPU reads it back
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0020, 4'hF, 32'hDEAD_BEEF);
        settle();
        chk("dbg write c0 ack", 32'(dbg_ack), 32'd0);
        advance();
        settle();
        chk("dbg write c1 ram_we", 32'(ram_we), 32'hF);
        chk("dbg write c1 ram_din", ram_din, 32'hDEAD_BEEF);
        advance();
        settle();
        chk("dbg write c2 ack", 32'(dbg_ack), 32'd1);
        chk("dbg write keeps rdata", dbg_rdata, 32'h0);
        advance();
        applyStimulus(0, 1, 32'h8000_0020, 4'b0000, 0, 0, 0, 0, 0);
        settle();
        chk("dbg write c3 ack", 32'(dbg_ack), 32'd0);
        advance();
        settle(); advance();
        settle();
        chk("cpu readback", cpu_rdata, 32'hDEAD_BEEF);
        advance();

        // Simultaneous requests from reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); advance();
        applyStimulus(0, 1, 32'h8000_0010, 4'b0000, 0, 1, 32'h8000_0020, 4'b0000, 0);
        settle(); advance();
        settle();
        chk("tie c1 cpu first", ram_addr, 32'h8000_0010);
        advance();
        settle();
        chk("tie c2 cpu done", 32'(cpu_stall), 32'd0);
        chk("tie c2 no ack", 32'(dbg_ack), 32'd0);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0020, 4'b0000, 0);
        settle();
        chk("tie c3 ram_ce", 32'(ram_ce), 32'd0);
        advance();
        settle();
        chk("tie c4 dbg addr", ram_addr, 32'h8000_0020);
        advance();
        settle();
        chk("tie c5 ack", 32'(dbg_ack), 32'd1);
        chk("tie c5 dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("tie c6 ack", 32'(dbg_ack), 32'd0);
        advance();

        // Debug request dropped during its access cycle still completes
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0010, 4'b0000, 0);
        settle(); advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h8000_0010, 4'b0000, 0);
        settle();
        chk("drop c1 ram_ce", 32'(ram_ce), 32'd1);
        advance();
        settle();
        chk("drop c2 ack", 32'(dbg_ack), 32'd1);
        chk("drop c2 dbg_rdata", dbg_rdata, 32'h1234_5678);
        advance();
        settle();
        chk("drop c3 ack once", 32'(dbg_ack), 32'd0);
        advance();

        // Reset during a debug access cycle
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0020, 4'b0000, 0);
        settle(); advance();
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h8000_0020, 4'b0000, 0);
        settle();
        chk("rst acc c1 ram_ce", 32'(ram_ce), 32'd1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst acc c2 ram_ce", 32'(ram_ce), 32'd0);
        chk("rst acc c2 ack", 32'(dbg_ack), 32'd0);
        chk("rst acc c2 dbg_rdata", dbg_rdata, 32'h0);
        advance();
        settle();
        chk("rst acc c3 ack", 32'(dbg_ack), 32'd0);
        advance();

        // Randomized traffic
        cpu_fin = 0; dbg_fin = 0; rst_seen = 0; cpu_active = 0; dbg_active = 0;
        for (int n = 0; n < 3000; n++) begin
            randomStimulus();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL use one clock and one synchronous reset: cpu_clk_50M is the sole clock (rising edge); cpu_rst is synchronous and active-high.
REQ-002 SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- cpu_clk_50M  in  1  system clock
- cpu_rst  in  1  synchronous active-high reset
- cpu_ce  in  1  MEM-stage data access request
- cpu_addr  in  32  byte address
- cpu_we  in  4  byte write enables (0000 = read)
- cpu_din  in  32  write data, lane-aligned
- cpu_stall  out  1  freeze pipeline
- cpu_rdata  out  32  read data
- dbg_req  in  1  debug/loader access request
- dbg_addr  in  32  byte address
- dbg_we  in  4  byte write enables
- dbg_din  in  32  write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  read data
- ram_ce  out  1  RAM enable
- ram_we  out  4  RAM byte writes
- ram_addr  out  32  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid one cycle after ram_ce

Function
REQ-003 SHALL implement FSM states IDLE, CPU_ACC, DBG_ACC, RESP; owner register records the granted requester (CPU or DBG).
REQ-004 IDLE: no request -> stay IDLE; any request -> winner per REQ-010, go to CPU_ACC or DBG_ACC.
REQ-005 CPU_ACC/DBG_ACC last exactly 1 cycle: ram_ce=1, ram_addr/ram_we/ram_din taken combinationally from the owner's inputs; next state RESP.
REQ-006 RESP lasts exactly 1 cycle: capture ram_dout into owner's rdata register (reads only; writes leave rdata unchanged); DBG owner -> dbg_ack=1; next state IDLE unconditionally.
REQ-007 ram_ce=0, ram_we=0000 in IDLE and RESP; ram_addr/ram_din = 0 whenever ram_ce=0.
REQ-008 cpu_stall = cpu_ce AND NOT (state==RESP AND owner==CPU); latency request-to-completion = 3 cycles (IDLE, ACC, RESP).
REQ-009 cpu_rdata, dbg_rdata registered, held until the next read by the same requester.
REQ-010 Default arbitration: fixed priority, CPU wins simultaneous requests.
REQ-011 Requesters hold address/we/data stable until completion; dbg_req dropped after grant does not abort — access completes, dbg_ack still pulses.
REQ-012 dbg_ack never asserts outside RESP; at most one ack per grant.
REQ-013 Address is passed unmodified; no alignment checking (MEM stage already raises AdEL/AdES and suppresses cpu_ce).

Reset
REQ-014 While cpu_rst=1 at a clock edge: state<=IDLE, owner<=CPU, last-grant<=DBG, cpu_rdata<=0, dbg_rdata<=0.
REQ-015 Reset mid-access: the following cycle ram_ce=0, no dbg_ack, no rdata update; in-flight access abandoned.
REQ-016 After reset, all outputs 0 except cpu_stall, which follows cpu_ce.

Configuration
REQ-017 Macro DMEM_ARB_RR_EN defined: simultaneous requests in IDLE grant the requester NOT in last-grant; last-grant updates on each grant.
REQ-018 Macro DMEM_ARB_RR_EN undefined: fixed CPU priority per REQ-010; last-grant register absent.

Verification
REQ-019 CPU read: ram word 0x80000010=0x12345678, cpu_ce=1, cpu_we=0000 -> ram_ce cycle 1, cpu_stall=1 cycles 0-1, cpu_rdata=0x12345678 and cpu_stall=0 in cycle 2.
REQ-020 Debug write: dbg_req=1, addr 0x80000020, we=1111, din=0xDEADBEEF -> ram_we=1111 cycle 1, dbg_ack=1 cycle 2 only; later CPU read returns 0xDEADBEEF.
REQ-021 Simultaneous cpu_ce and dbg_req, macro off -> CPU served first (ack cycle 2), DBG granted cycle 3, dbg_ack cycle 5.
REQ-022 Same stimulus with DMEM_ARB_RR_EN, after reset (last-grant=DBG) -> CPU first; held requests next round -> DBG before CPU.
REQ-023 cpu_rst=1 in DBG_ACC cycle -> next cycle state IDLE, ram_ce=0, dbg_ack never pulses, dbg_rdata=0.
REQ-024 dbg_req deasserted in DBG_ACC cycle -> dbg_ack still pulses in RESP, exactly once.
